uart_tx_frame: RTL and testbench

Parametrised UART transmit frame engine: serializer, parity generator, frame FSM and output select in one block. Takes a parallel word with a valid strobe and emits start, data LSB-first, optional parity, and 1 or 2 stop bits on TX_OUT, advancing one bit per baud TICK. Sits between the TX data source (register file or FIFO pop) and the pad; TICK comes from the shared baud-rate generator.

---
 rtl/uart_tx_frame_if.sv | 24 ++
 rtl/uart_tx_frame.sv | 129 ++++++++++++
 tb/tb_uart_tx_frame.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// Parallel-side port bundle of the UART transmit frame engine.
// Handshake: DATA_VALID is a capture request that the engine samples only while BUSY=0
// (BUSY low acts as ready); a request raised while BUSY=1 is dropped, never queued.
interface uart_tx_frame_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  DATA_VALID;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic                  BUSY;
  logic                  DONE;

  modport master (
    output P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2,
    input  BUSY, DONE
  );

  modport slave (
    input  P_DATA, DATA_VALID, PAR_EN, PAR_TYP, STOP2,
    output BUSY, DONE
  );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit frame engine: start, data, optional parity and 1/2 stop bits,
// one bit per baud TICK, registered idle-high serial output.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                TICK,
  uart_tx_frame_if.slave      tx_if,
  output logic                TX_OUT,
  output logic [2:0]          state_dbg
);
  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARMED  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shadow_q;
  logic                  par_en_q, par_typ_q, stop2_q;
  logic                  capture;
  logic                  done_q, done_d;
  logic                  tx_q, tx_d;
  logic                  data_bit;

  // In STOP the counter holds the stop-bit index (0 = first, 1 = second).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_if.DATA_VALID) begin
          capture = 1'b1;
          state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (TICK) state_d = S_START;
      end
      S_START: begin
        if (TICK) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end
      S_DATA: begin
        if (TICK) begin
          if (cnt_q != LAST) begin
            cnt_d = cnt_q + 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = par_en_q ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (TICK) state_d = S_STOP;
      end
      S_STOP: begin
        if (TICK) begin
          if (stop2_q && (cnt_q == '0)) begin
            cnt_d = CW'(1);
          end else begin
            cnt_d   = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Line value is derived from the current state and registered, so it lags the
  // state transition by one cycle and cannot glitch.
  always_comb begin
    data_bit = MSB_FIRST ? shadow_q[LAST - cnt_q] : shadow_q[cnt_q];
    tx_d     = 1'b1;
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_bit;
      S_PARITY: tx_d = (^shadow_q) ^ par_typ_q;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      shadow_q  <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      done_q    <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
      if (capture) begin
        shadow_q  <= tx_if.P_DATA;
        par_en_q  <= tx_if.PAR_EN;
        par_typ_q <= tx_if.PAR_TYP;
        stop2_q   <= tx_if.STOP2;
      end
    end
  end

  assign TX_OUT     = tx_q;
  assign tx_if.BUSY = (state_q != S_IDLE);
  assign tx_if.DONE = done_q;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: an 8-bit LSB-first and a 7-bit MSB-first instance share
// clock, reset and a 16-cycle baud tick; line frames are decoded and scoreboarded.
module tb_uart_tx_frame;
  localparam int EW = 21;  // {len[4:0], bits[15:0]}, bit i = i-th transmitted bit

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic tx8, tx7;
  logic [2:0] st8, st7;
  int cyc = 0;

  uart_tx_frame_if #(.DATA_WIDTH(8)) if8 ();
  uart_tx_frame_if #(.DATA_WIDTH(7)) if7 ();

  uart_tx_frame #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_dut8 (
    .CLK(clk), .RST(rst), .TICK(tick), .tx_if(if8.slave), .TX_OUT(tx8), .state_dbg(st8)
  );
  uart_tx_frame #(.DATA_WIDTH(7), .MSB_FIRST(1'b1)) u_dut7 (
    .CLK(clk), .RST(rst), .TICK(tick), .tx_if(if7.slave), .TX_OUT(tx7), .state_dbg(st7)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int tcnt;
    tick = 1'b0;
    tcnt = 0;
    forever begin
      @(negedge clk);
      tick = (tcnt == 15);
      tcnt = (tcnt + 1) % 16;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp8_q[$];
  logic [EW-1:0] exp7_q[$];
  bit [1:0] mon_en;
  int start_cyc[2];
  int done_cnt8 = 0;
  int dbl_cnt = 0;
  logic prev_done8 = 1'b0;
  int frames8 = 0;
  int n_total = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic line(input int which);
    return (which == 0) ? tx8 : tx7;
  endfunction

  function automatic logic busy(input int which);
    return (which == 0) ? if8.BUSY : if7.BUSY;
  endfunction

  function automatic logic done(input int which);
    return (which == 0) ? if8.DONE : if7.DONE;
  endfunction

  // Reference frame: start 0, data bits in wire order, optional parity, stop bit(s).
  function automatic logic [EW-1:0] build(input logic [8:0] d, input int w, input bit msb,
                                          input bit pe, input bit pt, input bit s2);
    logic [15:0] bits;
    int n;
    logic par;
    bits = '0;
    bits[0] = 1'b0;
    n = 1;
    par = pt;
    for (int i = 0; i < w; i++) begin
      bits[n] = msb ? d[w-1-i] : d[i];
      par = par ^ d[i];
      n++;
    end
    if (pe) begin
      bits[n] = par;
      n++;
    end
    bits[n] = 1'b1;
    n++;
    if (s2) begin
      bits[n] = 1'b1;
      n++;
    end
    return {n[4:0], bits};
  endfunction

  always @(negedge clk) begin
    if (if8.DONE) done_cnt8 <= done_cnt8 + 1;
    if (if8.DONE && prev_done8) dbl_cnt <= dbl_cnt + 1;
    prev_done8 <= if8.DONE;
  end

  // Line decoder: finds the start edge, samples each bit at its centre.
  task automatic mon(input int which);
    logic [EW-1:0] e;
    logic [15:0] got;
    int len;
    forever begin
      @(negedge clk);
      if (mon_en[which] && line(which) === 1'b0) begin
        start_cyc[which] = cyc;
        if ((which == 0 && exp8_q.size() == 0) || (which == 1 && exp7_q.size() == 0)) begin
          chk("spurious_start", {31'd0, line(which)}, 32'd1);
          repeat (200) @(negedge clk);
        end else begin
          e = (which == 0) ? exp8_q.pop_front() : exp7_q.pop_front();
          len = int'(e[20:16]);
          got = '0;
          repeat (8) @(negedge clk);
          got[0] = line(which);
          for (int i = 1; i < len; i++) begin
            repeat (16) @(negedge clk);
            got[i] = line(which);
          end
          chk((which == 0) ? "frame8" : "frame7", {16'd0, got}, {16'd0, e[15:0]});
        end
      end
    end
  endtask

  initial mon(0);
  initial mon(1);

  // ---------------- driver tasks ----------------
  task automatic send(input int which, input logic [8:0] d, input bit pe, input bit pt,
                      input bit s2, input bit push);
    int k;
    k = 0;
    while (busy(which) !== 1'b0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk("idle_before_send", {31'd0, busy(which)}, 32'd0);
    if (which == 0) begin
      if8.P_DATA = d[7:0]; if8.PAR_EN = pe; if8.PAR_TYP = pt; if8.STOP2 = s2;
      if8.DATA_VALID = 1'b1;
      if (push) begin
        exp8_q.push_back(build(d, 8, 1'b0, pe, pt, s2));
        frames8++;
      end
    end else begin
      if7.P_DATA = d[6:0]; if7.PAR_EN = pe; if7.PAR_TYP = pt; if7.STOP2 = s2;
      if7.DATA_VALID = 1'b1;
      if (push) exp7_q.push_back(build(d, 7, 1'b1, pe, pt, s2));
    end
    @(negedge clk);
    if8.DATA_VALID = 1'b0;
    if7.DATA_VALID = 1'b0;
    chk("busy_after_capture", {31'd0, busy(which)}, 32'd1);
  endtask

  task automatic wait_done(input int which, output int dcyc);
    int k;
    dcyc = 0;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done(which) === 1'b1) break;
    end
    if (k == 400) begin
      chk("done_timeout", {31'd0, done(which)}, 32'd1);
    end else begin
      dcyc = cyc;
      chk("busy_low_at_done", {31'd0, busy(which)}, 32'd0);
      @(negedge clk);
      chk("done_one_cycle", {31'd0, done(which)}, 32'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int dc, dc0, k;
    bit bad_line;
    rst = 1'b1;
    mon_en = 2'b11;
    if8.P_DATA = '0; if8.DATA_VALID = 1'b0; if8.PAR_EN = 1'b0; if8.PAR_TYP = 1'b0; if8.STOP2 = 1'b0;
    if7.P_DATA = '0; if7.DATA_VALID = 1'b0; if7.PAR_EN = 1'b0; if7.PAR_TYP = 1'b0; if7.STOP2 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx8", {31'd0, tx8}, 32'd1);
    chk("rst_tx7", {31'd0, tx7}, 32'd1);
    chk("rst_busy", {31'd0, if8.BUSY}, 32'd0);
    chk("rst_done", {31'd0, if8.DONE}, 32'd0);
    chk("rst_state", {29'd0, st8}, 32'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // A5 with even parity, one stop: 11 bits, DONE 11*16-1 cycles after start edge
    send(0, 9'h0A5, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_done(0, dc);
    chk("a5_frame_length", dc - start_cyc[0], 32'd175);

    // parity polarity on a single set bit
    send(0, 9'h001, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_done(0, dc);
    send(0, 9'h001, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_done(0, dc);
    send(0, 9'h0A5, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done(0, dc);

    // 7-bit MSB-first, two stop bits: 10 bit periods
    send(1, 9'h040, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_done(1, dc);
    chk("w7_frame_length", dc - start_cyc[1], 32'd159);

    for (int i = 0; i < 4; i++) begin
      send(0, 9'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b1);
      wait_done(0, dc);
      send(1, 9'($urandom_range(0, 127)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'b1);
      wait_done(1, dc);
    end

    // request while busy is dropped
    dc0 = done_cnt8;
    send(0, 9'h0A5, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (40) @(negedge clk);
    if8.P_DATA = 8'h3C; if8.PAR_EN = 1'b0; if8.STOP2 = 1'b1; if8.DATA_VALID = 1'b1;
    @(negedge clk);
    if8.DATA_VALID = 1'b0;
    wait_done(0, dc);
    repeat (64) @(negedge clk);
    chk("drop_done_count", done_cnt8 - dc0, 32'd1);

    // back-to-back with DATA_VALID held through DONE
    if8.P_DATA = 8'h55; if8.PAR_EN = 1'b0; if8.PAR_TYP = 1'b0; if8.STOP2 = 1'b0;
    if8.DATA_VALID = 1'b1;
    exp8_q.push_back(build(9'h055, 8, 1'b0, 1'b0, 1'b0, 1'b0));
    exp8_q.push_back(build(9'h0AA, 8, 1'b0, 1'b0, 1'b0, 1'b0));
    frames8 += 2;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (if8.DONE === 1'b1) break;
    end
    chk("b2b_first_done", {31'd0, if8.DONE}, 32'd1);
    dc = cyc;
    if8.P_DATA = 8'hAA;
    @(negedge clk);
    if8.DATA_VALID = 1'b0;
    chk("b2b_busy_again", {31'd0, if8.BUSY}, 32'd1);
    for (k = 0; k < 100 && start_cyc[0] <= dc; k++) @(negedge clk);
    chk("b2b_gap", start_cyc[0] - dc, 32'd17);
    wait_done(0, dc);

    // reset in data bit 3 of FF aborts the frame
    mon_en[0] = 1'b0;
    send(0, 9'h0FF, 1'b1, 1'b0, 1'b0, 1'b0);
    for (k = 0; k < 100 && tx8 !== 1'b0; k++) @(negedge clk);
    repeat (4 * 16 + 8) @(negedge clk);
    chk("ff_bit3_line", {31'd0, tx8}, 32'd1);
    chk("ff_bit3_state", {29'd0, st8}, 32'd3);
    dc0 = done_cnt8;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_tx", {31'd0, tx8}, 32'd1);
    chk("abort_busy", {31'd0, if8.BUSY}, 32'd0);
    chk("abort_done", {31'd0, if8.DONE}, 32'd0);
    bad_line = 1'b0;
    repeat (48) begin
      @(negedge clk);
      if (tx8 !== 1'b1 || if8.BUSY !== 1'b0) bad_line = 1'b1;
    end
    chk("abort_line_idle", {31'd0, bad_line}, 32'd0);
    chk("abort_no_done", done_cnt8 - dc0, 32'd0);
    mon_en[0] = 1'b1;
    send(0, 9'h000, 1'b1, 1'b0, 1'b0, 1'b1);
    wait_done(0, dc);

    repeat (40) @(negedge clk);
    chk("exp8_drained", exp8_q.size(), 32'd0);
    chk("exp7_drained", exp7_q.size(), 32'd0);
    chk("done_count8", done_cnt8, frames8);
    chk("done_never_double", dbl_cnt, 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
